// File: rtl/mips_instr_reg.sv
// Byte-assembled MIPS instruction register with fetch-order checking and a completed-fetch counter.
// Optional registered class flags are enabled by defining MIPS_IR_CLASS_EN.
module mips_instr_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IRW   = 32,
    parameter int unsigned CNTW  = 16,
    localparam int unsigned NB   = IRW / WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memdata,
    input  logic [NB-1:0]    irwrite,
    input  logic             err_clr,
    output logic [IRW-1:0]   instr,
    output logic [5:0]       op,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [5:0]       funct,
    output logic [15:0]      imm,
    output logic             instr_valid,
    output logic             seq_err,
    output logic [CNTW-1:0]  fetch_cnt,
    output logic             is_lb,
    output logic             is_sb,
    output logic             is_rtype,
    output logic             is_beq,
    output logic             is_j,
    output logic             is_ill
);

    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e          state_q, state_d;
    logic [IRW-1:0]  instr_q, instr_d;
    logic [NB-1:0]   loaded_q, loaded_d;
    logic [IW-1:0]   exp_idx_q, exp_idx_d;
    logic            valid_q, valid_d;
    logic            seq_err_q, seq_err_d;
    logic [CNTW-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [NB-1:0]   start_pat;
    logic [NB-1:0]   lane_pat;

    always_comb begin
        instr_d = instr_q;
        for (int i = 0; i < int'(NB); i++) begin
            if (irwrite[i]) instr_d[i*WIDTH +: WIDTH] = memdata;
        end
    end

    always_comb begin
        start_pat   = {1'b1, {(NB-1){1'b0}}};
        lane_pat    = {{(NB-1){1'b0}}, 1'b1} << exp_idx_q;
        state_d     = state_q;
        loaded_d    = loaded_q;
        exp_idx_d   = exp_idx_q;
        valid_d     = valid_q;
        fetch_cnt_d = fetch_cnt_q;
        // A strobe error in the same cycle overrides err_clr below.
        seq_err_d   = err_clr ? 1'b0 : seq_err_q;

        if (irwrite == '0) begin
            // hold
        end else if (irwrite == start_pat) begin
            state_d   = StFill;
            loaded_d  = start_pat;
            exp_idx_d = IW'(NB - 2);
            valid_d   = 1'b0;
        end else if (state_q == StFill && irwrite == lane_pat) begin
            loaded_d = loaded_q | irwrite;
            if (exp_idx_q == '0) begin
                state_d     = StDone;
                valid_d     = 1'b1;
                fetch_cnt_d = fetch_cnt_q + 1'b1;
            end else begin
                exp_idx_d = exp_idx_q - 1'b1;
            end
        end else begin
            state_d   = StIdle;
            loaded_d  = '0;
            valid_d   = 1'b0;
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            loaded_q    <= '0;
            exp_idx_q   <= IW'(NB - 1);
            valid_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            loaded_q    <= loaded_d;
            exp_idx_q   <= exp_idx_d;
            valid_q     <= valid_d;
            seq_err_q   <= seq_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign funct       = instr_q[5:0];
    assign imm         = instr_q[15:0];
    assign instr_valid = valid_q;
    assign seq_err     = seq_err_q;
    assign fetch_cnt   = fetch_cnt_q;

`ifdef MIPS_IR_CLASS_EN
    logic [5:0] class_q, class_d;
    logic       done;

    // valid only rises on a lane-0 completion, since it is always low while filling.
    assign done = valid_d & ~valid_q;

    always_comb begin
        class_d = class_q;
        if (!valid_d) class_d = '0;
        if (done) begin
            case (instr_d[31:26])
                6'b100000: class_d = 6'b100000;
                6'b101000: class_d = 6'b010000;
                6'b000000: class_d = 6'b001000;
                6'b000100: class_d = 6'b000100;
                6'b000010: class_d = 6'b000010;
                default:   class_d = 6'b000001;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) class_q <= '0;
        else       class_q <= class_d;
    end

    assign {is_lb, is_sb, is_rtype, is_beq, is_j, is_ill} = class_q;
`else
    assign {is_lb, is_sb, is_rtype, is_beq, is_j, is_ill} = 6'b000000;
`endif

endmodule

// File: tb/tb_mips_instr_reg.sv
// Scoreboarded random/directed bench for mips_instr_reg against a behavioural fetch model.
module tb_mips_instr_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  memdata;
    logic [3:0]  irwrite;
    logic        err_clr;
    logic [31:0] instr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        instr_valid, seq_err;
    logic [15:0] fetch_cnt;
    logic        is_lb, is_sb, is_rtype, is_beq, is_j, is_ill;

    always #5 clk = ~clk;

    mips_instr_reg dut (
        .clk(clk), .reset(reset), .memdata(memdata), .irwrite(irwrite), .err_clr(err_clr),
        .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
        .instr_valid(instr_valid), .seq_err(seq_err), .fetch_cnt(fetch_cnt),
        .is_lb(is_lb), .is_sb(is_sb), .is_rtype(is_rtype), .is_beq(is_beq), .is_j(is_j),
        .is_ill(is_ill)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        err;
        logic [15:0] cnt;
        logic [5:0]  flags;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Behavioural model: bytes of the word, next lane the fetch expects (-1 = none).
    logic [7:0]  m_bytes[4];
    int          m_next;
    logic        m_valid, m_err;
    logic [15:0] m_cnt;
    logic [5:0]  m_flags;

    function automatic logic [5:0] classify(input logic [5:0] opc);
`ifdef MIPS_IR_CLASS_EN
        if (opc == 6'd32) return 6'b100000;
        if (opc == 6'd40) return 6'b010000;
        if (opc == 6'd0)  return 6'b001000;
        if (opc == 6'd4)  return 6'b000100;
        if (opc == 6'd2)  return 6'b000010;
        return 6'b000001;
`else
        return 6'b000000 & {opc[0], 5'b00000};
`endif
    endfunction

    function automatic logic [31:0] m_word();
        return {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] iw, input logic [7:0] md,
                              input logic clr);
        int n;
        bit bad;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
            m_next = -1; m_valid = 0; m_err = 0; m_cnt = 0; m_flags = 0;
            return;
        end
        bad = 0;
        n = 0;
        for (int i = 0; i < 4; i++) if (iw[i]) begin
            m_bytes[i] = md;
            n++;
        end
        if (n == 0) begin
        end else if (iw == 4'b1000) begin
            m_next = 2; m_valid = 0; m_flags = 0;
        end else if (n == 1 && m_next >= 0 && iw[m_next]) begin
            if (m_next == 0) begin
                m_valid = 1;
                m_cnt   = m_cnt + 16'd1;
                m_next  = -1;
                m_flags = classify(m_bytes[3][7:2]);
            end else begin
                m_next = m_next - 1;
            end
        end else begin
            bad = 1; m_valid = 0; m_next = -1; m_flags = 0;
        end
        if (bad) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.instr = m_word(); e.valid = m_valid; e.err = m_err; e.cnt = m_cnt; e.flags = m_flags;
        return e;
    endfunction

    // Drive one cycle at the negedge and record what the DUT should show after the next posedge.
    task automatic cycle(input logic rst, input logic [3:0] iw, input logic [7:0] md,
                         input logic clr);
        reset = rst; irwrite = iw; memdata = md; err_clr = clr;
        model_step(rst, iw, md, clr);
        q.push_back(snap());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 8'($urandom), 1'b0);
    endtask

    task automatic fetch(input logic [31:0] w, input int maxgap);
        for (int l = 3; l >= 0; l--) begin
            cycle(1'b0, 4'(1 << l), w[l*8 +: 8], 1'b0);
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("instr", instr, e.instr);
            chk("op", 32'(op), 32'(e.instr >> 26));
            chk("rs", 32'(rs), (e.instr >> 21) % 32);
            chk("rt", 32'(rt), (e.instr >> 16) % 32);
            chk("rd", 32'(rd), (e.instr >> 11) % 32);
            chk("funct", 32'(funct), e.instr % 64);
            chk("imm", 32'(imm), e.instr % 65536);
            chk("instr_valid", 32'(instr_valid), 32'(e.valid));
            chk("seq_err", 32'(seq_err), 32'(e.err));
            chk("fetch_cnt", 32'(fetch_cnt), 32'(e.cnt));
            chk("class_flags", 32'({is_lb, is_sb, is_rtype, is_beq, is_j, is_ill}),
                32'(e.flags));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lane;
        int r;
        reset = 1; irwrite = 0; memdata = 0; err_clr = 0;
        m_next = -1;
        @(negedge clk);
        // 1: reset then idle
        cycle(1'b1, 4'b0000, 8'h00, 1'b0);
        cycle(1'b1, 4'b1111, 8'hAB, 1'b1);
        idle(3);
        // 2: add r3,r1,r2
        fetch(32'h00221820, 0);
        idle(1);
        // 3: back-to-back class mix with gaps
        fetch(32'h80020004, 2);
        fetch(32'h08000010, 2);
        fetch(32'h10220001, 2);
        fetch(32'hA0030008, 2);
        idle(2);
        // 4: wrong lane, then clear and restart
        cycle(1'b0, 4'b1000, 8'h12, 1'b0);
        cycle(1'b0, 4'b0010, 8'h34, 1'b0);
        idle(1);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        fetch(32'h00851020, 1);
        // 5: multi-hot, then clear collides with another bad strobe
        cycle(1'b0, 4'b1100, 8'h5A, 1'b0);
        cycle(1'b0, 4'b0001, 8'h77, 1'b1);
        idle(1);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        // 6: reset mid-fetch, then counter wrap
        cycle(1'b0, 4'b1000, 8'hFF, 1'b0);
        cycle(1'b0, 4'b0100, 8'hEE, 1'b0);
        cycle(1'b1, 4'b0000, 8'h00, 1'b0);
        cycle(1'b0, 4'b0010, 8'h11, 1'b0);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        force dut.fetch_cnt_d = 16'hFFFF;
        reset = 0; irwrite = 0; memdata = 0; err_clr = 0;
        model_step(1'b0, 4'b0000, 8'h00, 1'b0);
        m_cnt = 16'hFFFF;
        q.push_back(snap());
        @(negedge clk);
        release dut.fetch_cnt_d;
        idle(1);
        fetch(32'h8C220000, 0);
        idle(1);
        // Random mix of legal progress, stray strobes, clears and resets
        lane = 3;
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                cycle(1'b0, 4'(1 << lane), 8'($urandom), ($urandom_range(0, 7) == 0));
                lane = (lane == 0) ? 3 : lane - 1;
            end else if (r < 75) begin
                cycle(1'b0, 4'b0000, 8'($urandom), ($urandom_range(0, 3) == 0));
            end else if (r < 90) begin
                cycle(1'b0, 4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            end else if (r < 97) begin
                cycle(1'b0, 4'b1000, 8'($urandom), 1'b0);
                lane = 2;
            end else begin
                cycle(1'b1, 4'($urandom), 8'($urandom), 1'($urandom));
                lane = 3;
            end
        end
        idle(2);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
